// File: rtl/add_sub.sv
// ============================================================================
// add_sub: WIDTH-bit adder/subtractor with a combinational result and a
// 1-cycle registered result plus Ovf/Zero/Neg flags (ADD_SUB_FLAGS_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q,
  output logic             out_valid,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  // Subtraction is A + ~B + 1; the carry-out then means "no borrow".
  always_comb begin
    bx   = B ^ {WIDTH{sel}};
    full = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, sel};
  end

  assign Sum  = full[WIDTH-1:0];
  assign Cout = full[WIDTH];

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic             cout_d,  cout_q;
  logic             valid_d, valid_q;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = Sum;
      cout_d = Cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign Sum_q     = sum_q;
  assign Cout_q    = cout_q;
  assign out_valid = valid_q;

`ifdef ADD_SUB_FLAGS_EN
  logic ovf_d,  ovf_q;
  logic zero_d, zero_q;
  logic neg_d,  neg_q;

  // bx[MSB] is B[MSB] inverted when subtracting, so one rule covers both modes.
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (in_valid) begin
      ovf_d  = (A[MSB] == bx[MSB]) && (Sum[MSB] != A[MSB]);
      zero_d = (Sum == '0);
      neg_d  = Sum[MSB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign Ovf  = ovf_q;
  assign Zero = zero_q;
  assign Neg  = neg_q;
`else
  assign Ovf  = 1'b0;
  assign Zero = 1'b0;
  assign Neg  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_sub.sv
// Directed bench for add_sub (WIDTH=4); flag expectations follow ADD_SUB_FLAGS_EN.
`default_nettype none
`timescale 1ns/1ps

module tb_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic       sel, in_valid;
  logic [3:0] Sum, Sum_q;
  logic       Cout, Cout_q, out_valid, Ovf, Zero, Neg;

`ifdef ADD_SUB_FLAGS_EN
  localparam logic F = 1'b1;
`else
  localparam logic F = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  add_sub #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel), .in_valid(in_valid),
    .Sum(Sum), .Cout(Cout), .Sum_q(Sum_q), .Cout_q(Cout_q),
    .out_valid(out_valid), .Ovf(Ovf), .Zero(Zero), .Neg(Neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [3:0] s, input logic c,
                            input logic v, input logic o, input logic z, input logic n);
    check({tag, ".Sum_q"},     32'(Sum_q),     32'(s));
    check({tag, ".Cout_q"},    32'(Cout_q),    32'(c));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".Ovf"},       32'(Ovf),       32'(o));
    check({tag, ".Zero"},      32'(Zero),      32'(z));
    check({tag, ".Neg"},       32'(Neg),       32'(n));
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s, input logic v);
    @(negedge clk);
    A = a; B = b; sel = s; in_valid = v;
  endtask

  task automatic edge_sample;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; A = 4'd0; B = 4'd0; sel = 1'b0; in_valid = 1'b1;
    edge_sample();
    check_regs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // Exhaustive combinational sweep
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          int exp_s;
          int exp_c;
          A = 4'(a); B = 4'(b); sel = s[0];
          #1;
          if (s == 0) begin
            exp_s = (a + b) % 16;
            exp_c = (a + b >= 16) ? 1 : 0;
          end else begin
            exp_s = (a - b + 16) % 16;
            exp_c = (a >= b) ? 1 : 0;
          end
          check("exh.Sum",  32'(Sum),  32'(exp_s));
          check("exh.Cout", 32'(Cout), 32'(exp_c));
        end
      end
    end

    A = 4'd9; B = 4'd8; sel = 1'b0; #1;
    check("add9p8.Sum", 32'(Sum), 32'd1);  check("add9p8.Cout", 32'(Cout), 32'd1);
    A = 4'd3; B = 4'd5; sel = 1'b0; #1;
    check("add3p5.Sum", 32'(Sum), 32'd8);  check("add3p5.Cout", 32'(Cout), 32'd0);
    A = 4'd3; B = 4'd5; sel = 1'b1; #1;
    check("sub3m5.Sum", 32'(Sum), 32'd14); check("sub3m5.Cout", 32'(Cout), 32'd0);
    A = 4'd5; B = 4'd5; sel = 1'b1; #1;
    check("sub5m5.Sum", 32'(Sum), 32'd0);  check("sub5m5.Cout", 32'(Cout), 32'd1);

    // Registered capture, then hold with in_valid low
    drive(4'd7, 4'd1, 1'b0, 1'b1);
    edge_sample();
    check_regs("cap7p1", 4'd8, 1'b0, 1'b1, F, 1'b0, F);
    drive(4'd3, 4'd3, 1'b1, 1'b0);
    edge_sample();
    check_regs("hold", 4'd8, 1'b0, 1'b0, F, 1'b0, F);

    // Back-to-back captures
    drive(4'd5, 4'd5, 1'b1, 1'b1);
    edge_sample();
    check_regs("b2b_5m5", 4'd0, 1'b1, 1'b1, 1'b0, F, 1'b0);
    drive(4'd9, 4'd8, 1'b0, 1'b1);
    edge_sample();
    check_regs("b2b_9p8", 4'd1, 1'b1, 1'b1, F, 1'b0, 1'b0);
    // 8 - 1 = 7: negative minus positive giving positive overflows
    drive(4'd8, 4'd1, 1'b1, 1'b1);
    edge_sample();
    check_regs("sub8m1", 4'd7, 1'b1, 1'b1, F, 1'b0, 1'b0);

    // Reset mid-stream discards the capture; combinational path unaffected
    drive(4'd7, 4'd1, 1'b0, 1'b1);
    rst = 1'b1;
    edge_sample();
    check_regs("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.Sum",  32'(Sum),  32'd8);
    check("rst_mid.Cout", 32'(Cout), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    check_regs("post_rst", 4'd8, 1'b0, 1'b1, F, 1'b0, F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
